// File: rtl/rv0_ifu.sv
// Instruction fetch unit: PC, in-order imem fetch, small fetch queue, redirect/flush handling.
// Latency: first request 1 cycle after reset release; a response is visible at the queue head 1 cycle later.
// Backpressure: if_ready_i=0 holds the head; issue credit (alloc + drop < IFQ_DEPTH) stops fetching when full.
//
// Ports:
//   clk_i, rst_ni                      core clock, async active-low reset
//   ct_target_i, ct_trans_i            control-transfer redirect from execute
//   imem_req_o/addr_o/gnt_i            fetch request handshake (held stable until granted)
//   imem_rvalid_i/rdata_i              in-order fetch responses
//   if_valid_o/insn_o/addr_o/ready_i   queue head towards decode
//   if_fault_o                         misaligned redirect target, fetch halted
module rv0_ifu #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] PC_RESET  = '0,
    parameter int              IFQ_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLEN-1:0] ct_target_i,
    input  logic            ct_trans_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            if_valid_o,
    output logic [31:0]     if_insn_o,
    output logic [XLEN-1:0] if_addr_o,
    input  logic            if_ready_i,
    output logic            if_fault_o
);

    localparam int AW = $clog2(IFQ_DEPTH);
    localparam int CW = $clog2(IFQ_DEPTH) + 1;

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_FAULT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [XLEN-1:0] r_pc;
    logic            r_pend;        // request raised last cycle and not yet granted
    logic            r_pend_stale;  // that pending request belongs to a flushed stream
    logic [XLEN-1:0] r_pend_addr;

    logic [XLEN-1:0]      r_q_addr [IFQ_DEPTH];
    logic [31:0]          r_q_insn [IFQ_DEPTH];
    logic [IFQ_DEPTH-1:0] r_q_full;
    logic [AW-1:0]        r_head;
    logic [AW-1:0]        r_tail;
    logic [AW-1:0]        r_fill;
    logic [CW-1:0]        r_cnt;   // allocated entries (filled or not)
    logic [CW-1:0]        r_unf;   // allocated entries still waiting for data
    logic [CW-1:0]        r_drop;  // responses still owed to flushed streams

    logic          w_credit;
    logic          w_grant;
    logic          w_grant_stale;
    logic          w_grant_live;
    logic          w_drop_nz;
    logic          w_unf_nz;
    logic          w_rsp_any;
    logic          w_rsp_drop;
    logic          w_rsp_fill;
    logic          w_pop;
    logic          w_misaligned;
    logic [CW-1:0] w_drop_nxt;

    // ------------------------------------------------------------------
    // Request side. The request is a function of registered state only,
    // so it never combinationally depends on gnt or a same-cycle redirect.
    // ------------------------------------------------------------------
    assign w_credit    = ({1'b0, r_cnt} + {1'b0, r_drop}) < (CW+1)'(IFQ_DEPTH);
    assign imem_req_o  = r_pend | ((r_state == S_FETCH) & w_credit);
    assign imem_addr_o = r_pend ? r_pend_addr : r_pc;

    assign w_grant       = imem_req_o & imem_gnt_i;
    // A grant belongs to the old stream if it was pending across a redirect
    // or coincides with one; its response must be discarded, not queued.
    assign w_grant_stale = w_grant & (ct_trans_i | (r_pend & r_pend_stale));
    assign w_grant_live  = w_grant & ~w_grant_stale;

    // ------------------------------------------------------------------
    // Response side. Owed drops are retired first (responses are in order);
    // responses with nothing owed and nothing allocated are ignored.
    // ------------------------------------------------------------------
    assign w_drop_nz  = (r_drop != '0);
    assign w_unf_nz   = (r_unf != '0);
    assign w_rsp_any  = imem_rvalid_i & (w_drop_nz | w_unf_nz);
    assign w_rsp_drop = imem_rvalid_i & w_drop_nz;
    assign w_rsp_fill = imem_rvalid_i & ~w_drop_nz & w_unf_nz & ~ct_trans_i;

    assign if_valid_o = r_q_full[r_head];
    assign if_insn_o  = r_q_insn[r_head];
    assign if_addr_o  = r_q_addr[r_head];
    assign w_pop      = if_valid_o & if_ready_i;

    assign w_misaligned = (ct_target_i[1:0] != 2'b00);
    assign if_fault_o   = (r_state == S_FAULT);

    // On redirect every unfilled entry turns into an owed response; a response
    // arriving in the same cycle settles one of them immediately.
    always_comb begin
        w_drop_nxt = r_drop;
        if (ct_trans_i) begin
            w_drop_nxt = r_drop + r_unf + CW'(w_grant_stale) - CW'(w_rsp_any);
        end else begin
            w_drop_nxt = r_drop + CW'(w_grant_stale) - CW'(w_rsp_drop);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:  w_state_nxt = S_FETCH;
            S_FETCH: if (ct_trans_i && w_misaligned) w_state_nxt = S_FAULT;
            S_FAULT: if (ct_trans_i && !w_misaligned) w_state_nxt = S_FETCH;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc         <= PC_RESET;
            r_pend       <= 1'b0;
            r_pend_stale <= 1'b0;
            r_pend_addr  <= '0;
            r_drop       <= '0;
        end else begin
            if (ct_trans_i) begin
                r_pc <= ct_target_i;
            end else if (w_grant_live) begin
                r_pc <= r_pc + XLEN'(4);
            end
            r_pend       <= imem_req_o & ~imem_gnt_i;
            r_pend_stale <= imem_req_o & ~imem_gnt_i & (ct_trans_i | (r_pend & r_pend_stale));
            if (imem_req_o && !imem_gnt_i) begin
                r_pend_addr <= imem_addr_o;
            end
            r_drop <= w_drop_nxt;
        end
    end

    // Fetch queue: allocate at tail on grant, fill in order at r_fill, pop at head.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < IFQ_DEPTH; i++) begin
                r_q_addr[i] <= '0;
                r_q_insn[i] <= '0;
            end
            r_q_full <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            r_fill   <= '0;
            r_cnt    <= '0;
            r_unf    <= '0;
        end else if (ct_trans_i) begin
            r_q_full <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            r_fill   <= '0;
            r_cnt    <= '0;
            r_unf    <= '0;
        end else begin
            if (w_grant_live) begin
                r_q_addr[r_tail] <= imem_addr_o;
                r_tail           <= r_tail + AW'(1);
            end
            if (w_rsp_fill) begin
                r_q_insn[r_fill] <= imem_rdata_i;
                r_q_full[r_fill] <= 1'b1;
                r_fill           <= r_fill + AW'(1);
            end
            if (w_pop) begin
                r_q_full[r_head] <= 1'b0;
                r_head           <= r_head + AW'(1);
            end
            r_cnt <= r_cnt + CW'(w_grant_live) - CW'(w_pop);
            r_unf <= r_unf + CW'(w_grant_live) - CW'(w_rsp_fill);
        end
    end

endmodule

// File: tb/tb_rv0_ifu.sv
// Directed bench for rv0_ifu: a behavioural instruction memory inside the tick task,
// in-order delivery/grant logs, and hand-computed expectations for each step.
module tb_rv0_ifu;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] ct_target_i;
    logic        ct_trans_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_insn_o;
    logic [31:0] if_addr_o;
    logic        if_ready_i;
    logic        if_fault_o;

    rv0_ifu #(
        .XLEN     (32),
        .PC_RESET (32'h100),
        .IFQ_DEPTH(2)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ct_target_i  (ct_target_i),
        .ct_trans_i   (ct_trans_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .if_valid_o   (if_valid_o),
        .if_insn_o    (if_insn_o),
        .if_addr_o    (if_addr_o),
        .if_ready_i   (if_ready_i),
        .if_fault_o   (if_fault_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] a;
        int          due;
    } rsp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] i;
    } dlv_t;

    rsp_t        rq[$];
    dlv_t        dq[$];
    logic [31:0] gq[$];
    int          gcyc[$];
    int          cyc = 0;
    int          lat = 1;
    int          checks = 0;
    int          errors = 0;
    int          n0;
    int          g0;
    int          d0;
    bit          ok;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: at the falling edge the memory model answers due
    // requests and the grant/delivery logs are updated; returns 1 time unit
    // after the following rising edge, where inputs are changed and checks run.
    task automatic tick();
        rsp_t r;
        dlv_t d;
        @(negedge clk_i);
        cyc++;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            r = rq.pop_front();
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem(r.a);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
        end
        if (imem_req_o && imem_gnt_i) begin
            r.a   = imem_addr_o;
            r.due = cyc + lat;
            rq.push_back(r);
            gq.push_back(imem_addr_o);
            gcyc.push_back(cyc);
        end
        if (if_valid_o && if_ready_i) begin
            d.a = if_addr_o;
            d.i = if_insn_o;
            dq.push_back(d);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_dq(input int n, input int budget, output bit done);
        done = (dq.size() >= n);
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            done = (dq.size() >= n);
        end
    endtask

    task automatic redirect(input logic [31:0] tgt);
        ct_target_i = tgt;
        ct_trans_i  = 1'b1;
        tick();
        ct_trans_i  = 1'b0;
    endtask

    initial begin
        rst_ni        = 1'b1;
        ct_target_i   = 32'h0;
        ct_trans_i    = 1'b0;
        imem_gnt_i    = 1'b1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        if_ready_i    = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_req",   imem_req_o,  0);
        chk("rst_addr",  imem_addr_o, 32'h100);
        chk("rst_valid", if_valid_o,  0);
        chk("rst_insn",  if_insn_o,   0);
        chk("rst_iaddr", if_addr_o,   0);
        chk("rst_fault", if_fault_o,  0);
        ticks(2);
        rst_ni = 1'b1;
        chk("boot_noreq", imem_req_o, 0);
        tick();
        chk("first_req",  imem_req_o,  1);
        chk("first_addr", imem_addr_o, 32'h100);

        // Downstream stalled: exactly two grants, then credit stops requests.
        ticks(8);
        chk("full_grants", gq.size(), 2);
        chk("full_noreq",  imem_req_o, 0);
        chk("full_valid",  if_valid_o, 1);
        chk("full_haddr",  if_addr_o,  32'h100);
        chk("full_hinsn",  if_insn_o,  mem(32'h100));
        if_ready_i = 1'b1;
        tick();
        if_ready_i = 1'b0;
        chk("pop_req",   imem_req_o,  1);
        chk("pop_addr",  imem_addr_o, 32'h108);
        chk("pop_haddr", if_addr_o,   32'h104);
        ticks(4);
        chk("pop_grants", gq.size(), 3);
        chk("pop_noreq",  imem_req_o, 0);
        chk("pop_dlv",    dq.size(), 1);
        chk("pop_hold",   if_addr_o, 32'h104);

        // Streaming: in-order delivery with matching addresses and data.
        if_ready_i = 1'b1;
        wait_dq(6, 40, ok);
        chk("stream_timeout", ok, 1);
        for (int i = 0; i < 6; i++) begin
            chk("stream_addr", dq[i].a, 32'h100 + 32'(4 * i));
            chk("stream_insn", dq[i].i, mem(32'h100 + 32'(4 * i)));
        end
        chk("g0_addr", gq[0], 32'h100);
        chk("g1_addr", gq[1], 32'h104);
        chk("g2_addr", gq[2], 32'h108);
        chk("g01_b2b", gcyc[1] - gcyc[0], 1);

        // Redirect with responses in flight: old responses are discarded.
        lat = 4;
        ticks(10);
        redirect(32'h2000);
        chk("flush_valid", if_valid_o, 0);
        n0 = dq.size();
        wait_dq(n0 + 1, 40, ok);
        chk("redir_timeout", ok, 1);
        chk("redir_addr", dq[n0].a, 32'h2000);
        chk("redir_insn", dq[n0].i, mem(32'h2000));

        // Redirect while a request waits for grant.
        lat = 1;
        imem_gnt_i = 1'b0;
        ticks(8);
        redirect(32'h5000);
        chk("pend_held", imem_req_o, 1);
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        chk("pend_tgt_req",  imem_req_o,  1);
        chk("pend_tgt_addr", imem_addr_o, 32'h5000);
        ticks(3);
        chk("pend2_req",  imem_req_o,  1);
        chk("pend2_addr", imem_addr_o, 32'h5000);
        redirect(32'h6000);
        chk("hold1_addr", imem_addr_o, 32'h5000);
        tick();
        chk("hold2_req",  imem_req_o,  1);
        chk("hold2_addr", imem_addr_o, 32'h5000);
        n0 = dq.size();
        imem_gnt_i = 1'b1;
        tick();
        chk("stale_grant", gq[gq.size()-1], 32'h5000);
        chk("after_req",   imem_req_o, 1);
        chk("after_addr",  imem_addr_o, 32'h6000);
        wait_dq(n0 + 1, 20, ok);
        chk("pend_timeout", ok, 1);
        chk("pend_dlv_addr", dq[n0].a, 32'h6000);
        chk("pend_dlv_insn", dq[n0].i, mem(32'h6000));

        // Misaligned target halts fetch; an aligned redirect resumes it.
        ticks(4);
        redirect(32'h2002);
        chk("fault_set",   if_fault_o, 1);
        chk("fault_noreq", imem_req_o, 0);
        chk("fault_valid", if_valid_o, 0);
        g0 = gq.size();
        d0 = dq.size();
        ticks(4);
        chk("fault_hold",    if_fault_o, 1);
        chk("fault_noreq2",  imem_req_o, 0);
        chk("fault_nogrant", gq.size(), g0);
        chk("fault_nodlv",   dq.size(), d0);
        redirect(32'h3000);
        chk("fault_clr",  if_fault_o, 0);
        chk("resume_req", imem_req_o, 1);
        chk("resume_addr", imem_addr_o, 32'h3000);
        n0 = dq.size();
        wait_dq(n0 + 1, 20, ok);
        chk("resume_timeout", ok, 1);
        chk("resume_dlv", dq[n0].a, 32'h3000);

        // Reset with responses outstanding: late responses are ignored.
        lat = 3;
        ticks(4);
        rst_ni     = 1'b0;
        imem_gnt_i = 1'b0;
        #1;
        chk("mrst_req",   imem_req_o,  0);
        chk("mrst_addr",  imem_addr_o, 32'h100);
        chk("mrst_valid", if_valid_o,  0);
        chk("mrst_fault", if_fault_o,  0);
        tick();
        rst_ni = 1'b1;
        chk("mrst_boot", imem_req_o, 0);
        tick();
        chk("mrst_req1",  imem_req_o,  1);
        chk("mrst_addr1", imem_addr_o, 32'h100);
        ticks(5);
        chk("mrst_ignored", if_valid_o, 0);
        chk("mrst_addr2",   imem_addr_o, 32'h100);
        n0 = dq.size();
        imem_gnt_i = 1'b1;
        wait_dq(n0 + 1, 20, ok);
        chk("mrst_timeout", ok, 1);
        chk("mrst_dlv_addr", dq[n0].a, 32'h100);
        chk("mrst_dlv_insn", dq[n0].i, mem(32'h100));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv0_ifu.md
# rv0_ifu

Instruction fetch unit feeding the decode/execute path. Holds the program counter, issues in-order word fetches to instruction memory over a request/grant/rvalid handshake, and buffers returned instructions with their addresses in a small fetch queue. Consumes the execute-stage control-transfer result (`ct_target` and `ct_trans`): it flushes wrong-path instructions and restarts fetch at the target. It also detects misaligned targets.

## Interface
- `XLEN`, 32, datapath and address width
- `PC_RESET`, 'h0, first fetch address after reset (word aligned)
- `IFQ_DEPTH`, 2, fetch queue entries (power of 2, ≥2); also the outstanding-request bound
- `clk_i` in 1: core clock
- `rst_ni` in 1: reset, asynchronous, active-low
- `ct_target_i` in XLEN: control-transfer target from execute
- `ct_trans_i` in 1: single-cycle pulse; control transfer taken
- `imem_req_o` out 1: fetch request
- `imem_addr_o` out XLEN: fetch address, word aligned
- `imem_gnt_i` in 1: request accepted
- `imem_rvalid_i` in 1: response valid (in order, ≥1 cycle after grant)
- `imem_rdata_i` in 32: fetched instruction
- `if_valid_o` out 1: queue head holds an instruction
- `if_insn_o` out 32: head instruction
- `if_addr_o` out XLEN: head instruction address
- `if_ready_i` in 1: downstream accepts head
- `if_fault_o` out 1: misaligned target; fetch halted

## Operation
- FSM states: BOOT, FETCH, FAULT.
  - BOOT → FETCH unconditionally one cycle after reset release.
  - FETCH → FAULT on `ct_trans_i` with `ct_target_i[1:0]` != 0.
  - FAULT → FETCH on `ct_trans_i` with an aligned target.
- In FAULT: `if_fault_o`=1; no new requests are issued; outstanding responses are dropped.
- Queue entry is allocated at grant (`imem_req_o & imem_gnt_i`) with the address, and filled at `imem_rvalid_i` in order. The head is presented when filled.
- PC advances by 4 on grant (XLEN-bit wrap, no carry-out).
- Issue credit: request only when `alloc + drop < IFQ_DEPTH`.
  - `alloc` = allocated entries.
  - `drop` = responses still owed to a flushed stream.
- Req/gnt rule: once `imem_req_o` is raised, it and `imem_addr_o` stay stable until granted. A redirect never retracts a pending request.
- Pop: `if_valid_o & if_ready_i` frees the head.
- Redirect (`ct_trans_i`):
  - All queue entries are flushed.
  - Unfilled allocated entries are added to `drop`.
  - PC ← `ct_target_i`.
  - If a request is pending and ungranted, it completes at its old address and is counted into `drop`.
- Response while `drop` > 0: discarded, `drop`−1.

## Timing
- Reset values:
  - `imem_req_o`=0, `imem_addr_o`=`PC_RESET`
  - `if_valid_o`=0, `if_insn_o`=0, `if_addr_o`=0
  - `if_fault_o`=0
  - PC=`PC_RESET`, queue empty, `drop`=0, state BOOT
- First request: 1 cycle after `rst_ni` deasserts, with `imem_addr_o`=`PC_RESET`.
- Response latency: response in cycle M gives `if_valid_o`=1 in M+1 when the entry is the head (registered queue).
- Redirect latency: redirect in cycle N gives a request to the target in N+1. If a request was ungranted at N, the target request follows the cycle after that grant.
- Simultaneous events:
  - Redirect + grant in the same cycle: the granted request goes to `drop`; PC ← target (not target+4).
  - Redirect + rvalid: the response belongs to the old stream and is dropped.
  - Redirect + pop: flush wins; `if_valid_o`=0 in N+1.
  - Pop + fill in the same cycle: both honoured.
- Full queue: no requests while `alloc + drop` = `IFQ_DEPTH`. Requests resume the cycle after a pop or drop frees credit.
- Reset mid-operation: all state returns to reset values asynchronously. Responses arriving after reset are ignored (`drop`=0, no allocation).
- Backpressure: `if_ready_i`=0 holds the head stable. Credit stops requests so the queue never overflows.

## Test plan
- Reset, `PC_RESET`=0x100, `imem_gnt_i`=1, rvalid latency 1, `if_ready_i`=1 → requests 0x100, 0x104, 0x108; instructions are delivered in order with matching `if_addr_o`; back-to-back throughput after warm-up.
- `if_ready_i`=0, `IFQ_DEPTH`=2 → exactly 2 grants, then `imem_req_o`=0. Raise ready → one pop, then one new request.
- Two requests outstanding; `ct_trans_i` with target 0x2000 → both old responses discarded; next delivered instruction has `if_addr_o`=0x2000.
- Redirect in the cycle `imem_req_o` is high with `imem_gnt_i`=0 → address held until grant, that response is dropped, then a request to the target follows.
- `ct_trans_i` with target 0x2002 → `if_fault_o`=1 next cycle, no requests. Redirect to 0x3000 → fault clears, fetch resumes at 0x3000.
- Assert `rst_ni`=0 with one response outstanding, release → response arriving later is ignored; fetch restarts at `PC_RESET`.
